satarx_framer_wide: RTL and testbench



---
 rtl/satarx_framer_wide.sv | 198 +++++++++++++++++++
 tb/tb_satarx_framer_wide.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satarx_framer_wide.sv
// satarx_framer_wide: SATA receive framer with NW-dword output beats.
// Strips SOF/EOF framing from the 33-bit link word stream (bit 32 = primitive
// flag). Provides CONT junk suppression, HOLD transparency, a maximum frame
// length abort and a DROP state. There is no backpressure on either side.
// Optional build macro SATARX_FRAMER_STATS_EN adds saturating frame and
// abort counters (o_frame_count, o_abort_count).
//
// state  | meaning
// IDLE   | between frames, data words ignored, waiting for SOF
// DATA   | inside a frame, collecting payload dwords
// DROP   | frame overflowed, data ignored until SOF (or WTRM/SYNC/abort)
module satarx_framer_wide #(
    parameter int          NW           = 2,
    parameter int          MAX_WORDS    = 2049,
    parameter logic [32:0] P_SOF        = 33'h1_7cb5_3737,
    parameter logic [32:0] P_EOF        = 33'h1_7cb5_d5d5,
    parameter logic [32:0] P_WTRM       = 33'h1_7cb5_5858,
    parameter logic [32:0] P_SYNC       = 33'h1_7c95_b5b5,
    parameter logic [32:0] P_HOLD       = 33'h1_7caa_d5d5,
    parameter logic [32:0] P_CONT       = 33'h1_7caa_9999,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              S_AXIS_TVALID,
    input  logic [32:0]       S_AXIS_TDATA,
    input  logic              S_AXIS_TABORT,
    output logic              M_AXIS_TVALID,
    output logic [32*NW-1:0]  M_AXIS_TDATA,
    output logic [NW-1:0]     M_AXIS_TKEEP,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TABORT
`ifdef SATARX_FRAMER_STATS_EN
    ,
    output logic [15:0]       o_frame_count,
    output logic [15:0]       o_abort_count
`endif
);

    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t        state;
    logic [31:0]   pending;
    logic          pend_vld;
    logic [31:0]   slot [NW];
    logic [KW-1:0] k;
    logic [CW-1:0] count;
    logic          cont;

    logic              is_prim;
    logic              is_sof;
    logic              is_eof;
    logic              is_stop;
    logic              is_cont;
    logic              is_data;
    logic              in_data;
    logic              has_words;
    logic              k_last;
    logic [32*NW-1:0]  beat_data;
    logic [NW-1:0]     beat_keep;

    // HOLD and unlisted primitives match none of these and fall through as no-ops
    assign is_prim   = S_AXIS_TVALID && S_AXIS_TDATA[32];
    assign is_sof    = S_AXIS_TVALID && (S_AXIS_TDATA == P_SOF);
    assign is_eof    = S_AXIS_TVALID && (S_AXIS_TDATA == P_EOF);
    assign is_stop   = S_AXIS_TVALID && ((S_AXIS_TDATA == P_WTRM) || (S_AXIS_TDATA == P_SYNC));
    assign is_cont   = S_AXIS_TVALID && (S_AXIS_TDATA == P_CONT);
    assign is_data   = S_AXIS_TVALID && !S_AXIS_TDATA[32];
    assign in_data   = (state == S_DATA);
    assign has_words = (count != '0);
    assign k_last    = (k == KW'(NW - 1));

    // Beat contents if emitted now: filled slots below k, then the held-back word at k
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int j = 0; j < NW; j++) begin
            if (KW'(j) < k) begin
                beat_data[32*j +: 32] = slot[j];
                beat_keep[j]          = 1'b1;
            end else if (KW'(j) == k) begin
                beat_data[32*j +: 32] = pending;
                beat_keep[j]          = 1'b1;
            end
        end
    end

    // Framer state machine with registered beat/abort outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= S_IDLE;
            pending       <= '0;
            pend_vld      <= 1'b0;
            k             <= '0;
            count         <= '0;
            cont          <= 1'b0;
            for (int j = 0; j < NW; j++) slot[j] <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TABORT <= 1'b0;
        end else begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TABORT <= 1'b0;
            if (OPT_LOWPOWER) begin
                M_AXIS_TDATA <= '0;
                M_AXIS_TKEEP <= '0;
            end

            if (S_AXIS_TABORT) begin
                if (in_data && has_words) M_AXIS_TABORT <= 1'b1;
                state    <= S_IDLE;
                pend_vld <= 1'b0;
                k        <= '0;
                count    <= '0;
                cont     <= 1'b0;
            end else if (is_sof) begin
                // A new SOF restarts collection; an unfinished frame is aborted
                if (in_data && has_words) M_AXIS_TABORT <= 1'b1;
                state    <= S_DATA;
                pend_vld <= 1'b0;
                k        <= '0;
                count    <= '0;
                cont     <= 1'b0;
            end else if (is_stop) begin
                if (in_data && has_words) M_AXIS_TABORT <= 1'b1;
                state    <= S_IDLE;
                pend_vld <= 1'b0;
                k        <= '0;
                count    <= '0;
                cont     <= 1'b0;
            end else if (is_prim) begin
                cont <= is_cont;
                if (in_data && is_eof) begin
                    // The held-back word guarantees the last beat is never empty
                    if (pend_vld) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TLAST  <= 1'b1;
                        M_AXIS_TDATA  <= beat_data;
                        M_AXIS_TKEEP  <= beat_keep;
                    end
                    state    <= S_IDLE;
                    pend_vld <= 1'b0;
                    k        <= '0;
                    count    <= '0;
                end
            end else if (is_data && in_data && !cont) begin
                if (count == CW'(MAX_WORDS)) begin
                    M_AXIS_TABORT <= 1'b1;
                    state         <= S_DROP;
                    pend_vld      <= 1'b0;
                    k             <= '0;
                    count         <= '0;
                end else begin
                    count    <= count + 1'b1;
                    pending  <= S_AXIS_TDATA[31:0];
                    pend_vld <= 1'b1;
                    if (pend_vld) begin
                        slot[k] <= pending;
                        if (k_last) begin
                            M_AXIS_TVALID <= 1'b1;
                            M_AXIS_TDATA  <= beat_data;
                            M_AXIS_TKEEP  <= beat_keep;
                            k             <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SATARX_FRAMER_STATS_EN
    // Saturating counters fed from the registered beat/abort outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            o_frame_count <= '0;
            o_abort_count <= '0;
        end else begin
            if (M_AXIS_TVALID && M_AXIS_TLAST && (o_frame_count != 16'hffff))
                o_frame_count <= o_frame_count + 16'd1;
            if (M_AXIS_TABORT && (o_abort_count != 16'hffff))
                o_abort_count <= o_abort_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_satarx_framer_wide.sv
// Scoreboard bench for satarx_framer_wide: instance a uses default
// parameters (NW=2), instance b uses MAX_WORDS=4 for the overflow case.
module tb_satarx_framer_wide;

    localparam logic [32:0] P_SOF  = 33'h1_7cb5_3737;
    localparam logic [32:0] P_EOF  = 33'h1_7cb5_d5d5;
    localparam logic [32:0] P_WTRM = 33'h1_7cb5_5858;
    localparam logic [32:0] P_SYNC = 33'h1_7c95_b5b5;
    localparam logic [32:0] P_HOLD = 33'h1_7caa_d5d5;
    localparam logic [32:0] P_CONT = 33'h1_7caa_9999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_valid, b_valid, a_abort, b_abort;
    logic [32:0] a_data, b_data;
    logic        a_mv, b_mv, a_ml, b_ml, a_mab, b_mab;
    logic [63:0] a_md, b_md;
    logic [1:0]  a_mk, b_mk;
`ifdef SATARX_FRAMER_STATS_EN
    logic [15:0] a_fc, a_ac, b_fc, b_ac;
`endif

    satarx_framer_wide dut_a (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXIS_TVALID (a_valid),
        .S_AXIS_TDATA  (a_data),
        .S_AXIS_TABORT (a_abort),
        .M_AXIS_TVALID (a_mv),
        .M_AXIS_TDATA  (a_md),
        .M_AXIS_TKEEP  (a_mk),
        .M_AXIS_TLAST  (a_ml),
        .M_AXIS_TABORT (a_mab)
`ifdef SATARX_FRAMER_STATS_EN
        ,
        .o_frame_count (a_fc),
        .o_abort_count (a_ac)
`endif
    );

    satarx_framer_wide #(.NW(2), .MAX_WORDS(4)) dut_b (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXIS_TVALID (b_valid),
        .S_AXIS_TDATA  (b_data),
        .S_AXIS_TABORT (b_abort),
        .M_AXIS_TVALID (b_mv),
        .M_AXIS_TDATA  (b_md),
        .M_AXIS_TKEEP  (b_mk),
        .M_AXIS_TLAST  (b_ml),
        .M_AXIS_TABORT (b_mab)
`ifdef SATARX_FRAMER_STATS_EN
        ,
        .o_frame_count (b_fc),
        .o_abort_count (b_ac)
`endif
    );

    typedef struct packed {
        logic        abort;
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string who, input exp_t e, input logic v, input logic [63:0] d,
                               input logic [1:0] kp, input logic l, input logic ab);
        logic [63:0] mask;
        mask = {{32{e.keep[1]}}, {32{e.keep[0]}}};
        check({who, "_tvalid"}, 64'(v), 64'(!e.abort));
        check({who, "_tabort"}, 64'(ab), 64'(e.abort));
        check({who, "_tlast"}, 64'(l), 64'(e.last));
        if (!e.abort) begin
            check({who, "_tkeep"}, 64'(kp), 64'(e.keep));
            check({who, "_tdata"}, d & mask, e.data & mask);
        end
    endtask

    // Pop and compare whenever either DUT produces a beat or abort pulse
    always @(negedge clk) begin
        if (rst_n && (a_mv || a_mab)) begin
            if (qa.size() == 0) check("a_unexpected_out", {62'd0, a_mv, a_mab}, 64'd0);
            else compare_out("a", qa.pop_front(), a_mv, a_md, a_mk, a_ml, a_mab);
        end
        if (rst_n && (b_mv || b_mab)) begin
            if (qb.size() == 0) check("b_unexpected_out", {62'd0, b_mv, b_mab}, 64'd0);
            else compare_out("b", qb.pop_front(), b_mv, b_md, b_mk, b_ml, b_mab);
        end
    end

    function automatic logic [32:0] dw(input int i);
        return {1'b0, 32'hA500_0000 + 32'(i)};
    endfunction

    task automatic send(input bit to_b, input logic [32:0] w);
        @(posedge clk); #1;
        a_abort = 1'b0;
        b_abort = 1'b0;
        a_valid = !to_b;
        b_valid = to_b;
        if (to_b) b_data = w;
        else      a_data = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            a_valid = 1'b0;
            b_valid = 1'b0;
            a_abort = 1'b0;
            b_abort = 1'b0;
        end
    endtask

    task automatic push_beat(input bit to_b, input logic [32:0] w1, input logic [32:0] w0,
                             input logic [1:0] keep, input logic last);
        exp_t e;
        e.abort = 1'b0;
        e.data  = {w1[31:0], w0[31:0]};
        e.keep  = keep;
        e.last  = last;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic push_abort(input bit to_b);
        exp_t e;
        e = '0;
        e.abort = 1'b1;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tvalid"}, 64'(a_mv), 64'd0);
        check({tag, "_tlast"}, 64'(a_ml), 64'd0);
        check({tag, "_tabort"}, 64'(a_mab), 64'd0);
        check({tag, "_tkeep"}, 64'(a_mk), 64'd0);
        check({tag, "_tdata"}, a_md, 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_abort = 1'b0; b_abort = 1'b0;
        a_data  = '0;   b_data  = '0;
        #22;
        check_quiet("reset");
        rst_n = 1'b1;
        idle(2);

        // Five words, EOF: two full beats and a one-word last beat
        push_beat(0, dw(1), dw(0), 2'b11, 0);
        push_beat(0, dw(3), dw(2), 2'b11, 0);
        push_beat(0, 33'd0, dw(4), 2'b01, 1);
        send(0, P_SOF);
        for (int i = 0; i < 5; i++) send(0, dw(i));
        send(0, P_EOF);
        idle(3);

        // Four words: last beat is full
        push_beat(0, dw(11), dw(10), 2'b11, 0);
        push_beat(0, dw(13), dw(12), 2'b11, 1);
        send(0, P_SOF);
        for (int i = 10; i < 14; i++) send(0, dw(i));
        send(0, P_EOF);
        idle(3);

        // HOLD transparency
        push_beat(0, dw(21), dw(20), 2'b11, 0);
        push_beat(0, 33'd0, dw(22), 2'b01, 1);
        send(0, P_SOF);
        send(0, dw(20));
        send(0, dw(21));
        repeat (3) send(0, P_HOLD);
        send(0, dw(22));
        send(0, P_EOF);
        idle(3);

        // CONT junk suppression
        push_beat(0, dw(31), dw(30), 2'b11, 1);
        send(0, P_SOF);
        send(0, dw(30));
        send(0, P_CONT);
        for (int i = 0; i < 5; i++) send(0, dw(100 + i));
        send(0, P_HOLD);
        send(0, dw(31));
        send(0, P_EOF);
        idle(3);

        // SYNC mid-frame aborts; then an empty frame produces nothing
        push_beat(0, dw(41), dw(40), 2'b11, 0);
        push_abort(0);
        send(0, P_SOF);
        send(0, dw(40));
        send(0, dw(41));
        send(0, dw(42));
        send(0, P_SYNC);
        send(0, P_SOF);
        send(0, P_EOF);
        idle(3);

        // Link-layer abort input with one word collected
        push_abort(0);
        send(0, P_SOF);
        send(0, dw(50));
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_abort = 1'b1;
        idle(3);

        // WTRM with no words collected: no pulse
        send(0, P_SOF);
        send(0, P_WTRM);
        idle(3);

        // SOF mid-frame aborts and restarts a new frame
        push_beat(0, dw(61), dw(60), 2'b11, 0);
        push_abort(0);
        push_beat(0, 33'd0, dw(65), 2'b01, 1);
        send(0, P_SOF);
        send(0, dw(60));
        send(0, dw(61));
        send(0, dw(62));
        send(0, P_SOF);
        send(0, dw(65));
        send(0, P_EOF);
        idle(3);

        // MAX_WORDS=4 instance: fifth word aborts, following EOF is dropped
        push_beat(1, dw(71), dw(70), 2'b11, 0);
        push_abort(1);
        send(1, P_SOF);
        for (int i = 70; i < 75; i++) send(1, dw(i));
        send(1, P_EOF);
        send(1, dw(76));
        send(1, P_EOF);
        idle(3);

        // Reset while a beat is on the output
        push_beat(0, dw(81), dw(80), 2'b11, 0);
        send(0, P_SOF);
        send(0, dw(80));
        send(0, dw(81));
        send(0, dw(82));
        idle(1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
`ifdef SATARX_FRAMER_STATS_EN
        check("frame_count_reset", 64'(a_fc), 64'd0);
        check("abort_count_reset", 64'(a_ac), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, P_EOF);
        idle(4);

        check("a_scoreboard_left", 64'(qa.size()), 64'd0);
        check("b_scoreboard_left", 64'(qb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
